apb_req_arbiter: RTL
====================

Name: apb_req_arbiter

Overview:
- Shares the single APB master path between two independent requesters (e.g. CPU-side port and DMA-side port).
- Accepts one request at a time via a valid/ready handshake, with round-robin fairness.
- Drives the APB SETUP/ACCESS sequence to slave 1 or slave 2 (decoded from paddr[8]) and returns read data, or a timeout error, to the requester that owns the transfer.

Parameters:
- ADDR_W, 9, APB address width; bit ADDR_W-1 selects the slave.
- DATA_W, 8, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for pready before aborting with an error (must be >= 2).

Ports:
- pclk  in  1  APB clock; all state on rising edge.
- preset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  target address.
- req0_wdata  in  DATA_W  write data.
- req1_valid / req1_ready / req1_write / req1_addr / req1_wdata: same as requester 0.
- rsp0_valid  out  1  one-cycle completion pulse for requester 0.
- rsp1_valid  out  1  one-cycle completion pulse for requester 1.
- rsp_rdata  out  DATA_W  read data; valid with rsp*_valid.
- rsp_err  out  1  timeout error; valid with rsp*_valid.
- psel1  out  1  select for slave 1 (paddr[8] = 0).
- psel2  out  1  select for slave 2 (paddr[8] = 1).
- penable  out  1  APB access phase.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.

Behaviour:
- Reset (preset low, asynchronous):
  - All outputs 0; FSM in IDLE; wait counter 0.
  - Round-robin pointer set so requester 0 wins the first tie.
  - An in-flight transfer is dropped: psel and penable fall immediately and no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - reqN_ready = (state == IDLE) && grant == N. This is combinational from the valid inputs and the pointer; at most one ready is high per cycle.
  - On a handshake, latch write/addr/wdata and the grant index, then go to SETUP.
  - If neither requester is valid, stay in IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester other than the last one granted.
  - The pointer updates only on a handshake.
- SETUP (1 cycle):
  - psel1 = ~addr[8] and psel2 = addr[8]; penable = 0.
  - paddr, pwrite and pwdata come from the latched values; pwdata = 0 for reads.
  - Always goes to ACCESS.
- ACCESS:
  - penable = 1; psel, paddr, pwrite and pwdata are held stable.
  - If pready = 1: capture prdata on reads (0 on writes), err = 0, go to RESP.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT_CYCLES-1 with pready still 0, go to RESP with err = 1 and rdata = 0.
- RESP (1 cycle):
  - psel and penable = 0.
  - rspN_valid = 1 for the latched grant only; rsp_rdata and rsp_err are registered.
  - Clear the wait counter and return to IDLE.
  - rsp_rdata and rsp_err hold their values until the next RESP.
- Latency:
  - Handshake at cycle T; SETUP at T+1; ACCESS at T+2.
  - With zero wait states, RESP is at T+3 and the next handshake is possible at T+4 (4 cycles per transfer minimum).
  - Each wait state adds 1 cycle.
- Requests are never accepted outside IDLE. A requester holding valid simply waits.
- pready outside ACCESS is ignored.

Decomposition:
- Shared package apb_arb_pkg holds:
  - the state encoding (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3);
  - the slave-select bit index constant;
  - the default TIMEOUT_CYCLES.
- One natural sub-module, rr_arbiter2: 2-way round-robin grant with a pointer register. Its inputs are the two valids plus an accept strobe; its output is a one-hot grant.

Test Plan:
- Single write: req0 write addr 0x005 data 0xA5, pready tied 1.
  - req0_ready at T; psel1 = 1 at T+1/T+2; penable = 1 at T+2; rsp0_valid at T+3 with rsp_err = 0.
- Read from slave 2: req1 read addr 0x10C, prdata = 0x3C, 2 wait states.
  - psel2 = 1; penable held 3 cycles; rsp1_valid with rsp_rdata = 0x3C; pwdata = 0 throughout.
- Contention: both requesters valid continuously, 4 transfers each.
  - Grants alternate 0,1,0,1; each handshake is 4 cycles apart; no cycle has both readys high.
- Timeout: TIMEOUT_CYCLES = 16, pready held 0.
  - Transfer aborts after 16 ACCESS cycles; rsp0_valid with rsp_err = 1 and rsp_rdata = 0; the next request proceeds normally.
- Reset mid-transfer: deassert preset during ACCESS.
  - psel1, psel2 and penable go to 0 asynchronously; no rsp*_valid; after reset, requester 0 wins the first tie.
- Back-to-back single requester: req0 valid for 3 reads with prdata 0x11, 0x22, 0x33.
  - Three rsp0_valid pulses in order with the matching rdata; handshakes at T, T+4, T+8.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB arbiter: FSM state encoding,
// default geometry and the timeout default.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Default APB geometry; the top address bit picks slave 1 or slave 2.
  localparam int DEF_ADDR_W         = 9;
  localparam int DEF_DATA_W         = 8;
  localparam int SLV_SEL_BIT        = DEF_ADDR_W - 1;

  // Maximum ACCESS cycles spent waiting for pready before aborting.
  localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational from the valids and
// the "last granted" pointer; the pointer moves only when the grant is accepted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       accept,
  output logic [1:0] grant
);

  // 1 = requester 1 was granted last, so requester 0 wins the next tie.
  logic last;

  // One-hot grant: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

  // Pointer update on an accepted grant; reset favours requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (accept && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master path between two requesters. One command is accepted
// at a time (valid/ready), run through SETUP/ACCESS to slave 1 or 2, and the
// read data or a timeout error is returned to the owning requester.
//
// Handshake: a command on requester N transfers on a rising edge where
// reqN_valid and reqN_ready are both high. reqN_ready is only high in IDLE,
// for the arbitration winner, and never for both requesters in one cycle.
// The requester must hold valid and its command fields stable until then.
// rspN_valid is a single-cycle pulse with rsp_rdata/rsp_err; there is no
// backpressure on the response side.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W         = SLV_SEL_BIT + 1,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel1,
  output logic              psel2,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output state_e            fsm_state
);

  localparam int SEL   = ADDR_W - 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state;
  logic [1:0]        grant;
  logic              handshake;
  logic              owner;
  logic [CNT_W-1:0]  wait_cnt;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign fsm_state  = state;
  assign req0_ready = (state == ST_IDLE) && grant[0];
  assign req1_ready = (state == ST_IDLE) && grant[1];
  assign handshake  = (state == ST_IDLE) && (req0_valid || req1_valid);

  rr_arbiter2 u_rr (
    .clk    (pclk),
    .rst_n  (preset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .accept (handshake),
    .grant  (grant)
  );

  // Command fields of the arbitration winner.
  always_comb begin
    sel_write = req0_write;
    sel_addr  = req0_addr;
    sel_wdata = req0_wdata;
    if (grant[1]) begin
      sel_write = req1_write;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end
  end

  // Transfer FSM; every APB and response output is registered alongside the state.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      psel1      <= 1'b0;
      psel2      <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          if (handshake) begin
            owner  <= grant[1];
            pwrite <= sel_write;
            paddr  <= sel_addr;
            // Reads drive a clean zero on the write-data bus.
            pwdata <= sel_write ? sel_wdata : '0;
            psel1  <= ~sel_addr[SEL];
            psel2  <= sel_addr[SEL];
            state  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (pready) begin
            rsp_rdata  <= pwrite ? '0 : prdata;
            rsp_err    <= 1'b0;
            psel1      <= 1'b0;
            psel2      <= 1'b0;
            penable    <= 1'b0;
            rsp0_valid <= ~owner;
            rsp1_valid <= owner;
            state      <= ST_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            // Slave never answered: abort with an error and no data.
            rsp_rdata  <= '0;
            rsp_err    <= 1'b1;
            psel1      <= 1'b0;
            psel2      <= 1'b0;
            penable    <= 1'b0;
            rsp0_valid <= ~owner;
            rsp1_valid <= owner;
            state      <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          wait_cnt   <= '0;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
